window_frame_ctrl: RTL and testbench

- Frame sequencer for the 3x3 line-buffer window generator in the Canny pipeline (Gaussian/Sobel stages).
- Accepts a raster pixel stream with a valid/ready handshake and drives the window generator's shift enable.
- Tracks column/row position and flags which generated windows are fully inside the image, plus start-of-frame/end-of-line/end-of-frame markers.
- Sits between the pixel source (DMA/camera FIFO) and the window generator; the downstream filter stages consume its flags.

---
 rtl/window_frame_ctrl_if.sv | 23 ++
 rtl/window_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_window_frame_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/window_frame_ctrl_if.sv
// Pixel handshake and window-marker bundle between pixel source, frame sequencer and window generator.
// Slave is the sequencer; master is the source/consumer side.
interface window_frame_ctrl_if;
    logic       pix_valid;
    logic       pix_ready;
    logic       shift_en;
    logic       win_valid;
    logic       win_sof;
    logic       win_eol;
    logic       win_eof;
    logic [9:0] col_idx;
    logic [9:0] row_idx;

    modport master (
        output pix_valid,
        input  pix_ready, shift_en, win_valid, win_sof, win_eol, win_eof, col_idx, row_idx
    );

    modport slave (
        input  pix_valid,
        output pix_ready, shift_en, win_valid, win_sof, win_eol, win_eof, col_idx, row_idx
    );
endinterface

// File: rtl/window_frame_ctrl.sv
// 3x3 window frame sequencer: shift_en = accept (0 latency), window flags 1 cycle after accept;
// pix_ready only in PRIME/RUN, stalls hold all state. Optional stall watchdog under CTRL_TIMEOUT_EN.
module window_frame_ctrl #(
    parameter int WIDTH          = 640,
    parameter int DEPTH          = 512,
    parameter int KERNEL_SIZE    = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  en_fun,
    input  logic                  abort,
    window_frame_ctrl_if.slave    pix,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_cnt,
    output logic                  err_timeout
);
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

    localparam logic [9:0] LAST_COL  = 10'(WIDTH - 1);
    localparam logic [9:0] LAST_ROW  = 10'(DEPTH - 1);
    localparam logic [9:0] PRIME_ROW = 10'(KERNEL_SIZE - 2);
    localparam logic [9:0] FIRST_WIN = 10'(KERNEL_SIZE - 1);

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_col, r_row;
    logic [9:0]  r_col_idx, r_row_idx;
    logic        r_win_valid, r_win_sof, r_win_eol, r_win_eof;
    logic [15:0] r_frame_cnt;

    logic w_busy, w_accept, w_kill, w_timeout;
    logic w_last_col, w_frame_end, w_prime_end, w_in_win, w_win;

    assign w_busy      = (r_state == S_PRIME) || (r_state == S_RUN);
    assign w_accept    = pix.pix_valid & w_busy;
    assign w_kill      = abort | ~en_fun | w_timeout;
    assign w_last_col  = (r_col == LAST_COL);
    assign w_frame_end = w_last_col && (r_row == LAST_ROW);
    assign w_prime_end = w_last_col && (r_row == PRIME_ROW);
    assign w_in_win    = (r_row >= FIRST_WIN) && (r_col >= FIRST_WIN);
    // A kill in the same cycle suppresses the window that accept would otherwise produce
    assign w_win       = w_accept & w_in_win & ~w_kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_kill) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start)                    w_state_nxt = S_PRIME;
                S_PRIME: if (w_accept && w_prime_end)  w_state_nxt = S_RUN;
                S_RUN:   if (w_accept && w_frame_end)  w_state_nxt = S_DONE;
                S_DONE:                                w_state_nxt = S_IDLE;
                default:                               w_state_nxt = S_IDLE;
            endcase
        end
    end

    // r_col/r_row point at the next pixel; *_idx hold the last accepted one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_col_idx <= '0;
            r_row_idx <= '0;
        end else if (w_kill || r_state == S_IDLE) begin
            r_col     <= '0;
            r_row     <= '0;
            r_col_idx <= '0;
            r_row_idx <= '0;
        end else if (w_accept) begin
            r_col_idx <= r_col;
            r_row_idx <= r_row;
            if (w_last_col) begin
                r_col <= '0;
                if (r_row != LAST_ROW) r_row <= r_row + 10'd1;
            end else begin
                r_col <= r_col + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid <= 1'b0;
            r_win_sof   <= 1'b0;
            r_win_eol   <= 1'b0;
            r_win_eof   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_win_valid <= w_win;
            r_win_sof   <= w_win && (r_row == FIRST_WIN) && (r_col == FIRST_WIN);
            r_win_eol   <= w_win && w_last_col;
            r_win_eof   <= w_win && w_frame_end;
            if (r_state == S_DONE) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

`ifdef CTRL_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0] r_stall;
    logic          r_err;

    assign w_timeout = w_busy & ~w_accept & (r_stall == SW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            if (!w_busy || w_accept) r_stall <= '0;
            else                     r_stall <= r_stall + 1'b1;
            if (w_timeout)                                          r_err <= 1'b1;
            else if (r_state == S_IDLE && w_state_nxt == S_PRIME)   r_err <= 1'b0;
        end
    end

    assign err_timeout = r_err;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign pix.pix_ready = w_busy;
    assign pix.shift_en  = w_accept;
    assign pix.win_valid = r_win_valid;
    assign pix.win_sof   = r_win_sof;
    assign pix.win_eol   = r_win_eol;
    assign pix.win_eof   = r_win_eof;
    assign pix.col_idx   = r_col_idx;
    assign pix.row_idx   = r_row_idx;
    assign busy          = w_busy;
    assign done          = (r_state == S_DONE);
    assign frame_cnt     = r_frame_cnt;
endmodule

// File: tb/tb_window_frame_ctrl.sv
// Directed bench for window_frame_ctrl on an 8x4 frame: full frames, gaps, abort, busy start, reset, watchdog.
module tb_window_frame_ctrl;
    localparam int W = 8;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        en_fun = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, err_timeout;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int acc, nwin, nsof, neol, neof, ndone, last_acc_c, done_c;

    always #5 clk = ~clk;

    window_frame_ctrl_if pif();

    window_frame_ctrl #(
        .WIDTH(W), .DEPTH(D), .KERNEL_SIZE(3), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .en_fun(en_fun), .abort(abort),
        .pix(pif.slave), .busy(busy), .done(done), .frame_cnt(frame_cnt),
        .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Runs one frame from a start pulse; optional abort / busy-start / reset injected at an accept count
    task automatic run_frame(input bit toggle, input int abort_after, input int start_at, input int rst_after);
        bit stop, aborted, sb_done, prev_acc;
        acc = 0; nwin = 0; nsof = 0; neol = 0; neof = 0; ndone = 0;
        last_acc_c = -100; done_c = -1;
        en_fun = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop = 0; aborted = 0; sb_done = 0; prev_acc = 0;
        for (int c = 0; c < 300 && !stop; c++) begin
            pif.pix_valid = toggle ? ((c % 2 == 0) ? 1'b1 : 1'b0) : 1'b1;
            abort = 1'b0;
            start = 1'b0;
            if (abort_after > 0 && !aborted && acc == abort_after) abort = 1'b1;
            if (start_at > 0 && !sb_done && acc == start_at) begin
                start = 1'b1;
                sb_done = 1;
            end
            if (rst_after > 0 && acc == rst_after) begin
                rst_n = 1'b0;
                #1;
                chk("rst_ready", pif.pix_ready, 0);
                chk("rst_shift", pif.shift_en, 0);
                chk("rst_busy", busy, 0);
                chk("rst_win", pif.win_valid, 0);
                chk("rst_col", pif.col_idx, 0);
                chk("rst_row", pif.row_idx, 0);
                chk("rst_fcnt", frame_cnt, 0);
                chk("rst_done", done, 0);
                pif.pix_valid = 1'b0;
                stop = 1;
            end else begin
                @(negedge clk);
                if (aborted) begin
                    chk("abort_ready", pif.pix_ready, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_win", pif.win_valid, 0);
                    chk("abort_col", pif.col_idx, 0);
                    stop = 1;
                end else begin
                    if (acc > 0) begin
                        chk("col_idx", pif.col_idx, (acc - 1) % W);
                        chk("row_idx", pif.row_idx, (acc - 1) / W);
                    end
                    chk("win_model", pif.win_valid,
                        prev_acc && ((acc - 1) % W >= 2) && ((acc - 1) / W >= 2));
                    if (abort) aborted = 1;
                end
                if (pif.shift_en) begin acc++; last_acc_c = c; end
                if (pif.win_valid) nwin++;
                if (pif.win_sof) nsof++;
                if (pif.win_eol) neol++;
                if (pif.win_eof) neof++;
                if (done) begin ndone++; done_c = c; stop = 1; end
                prev_acc = pif.shift_en;
                @(posedge clk); #1;
            end
        end
        pif.pix_valid = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_frame(input int exp_fc);
        @(negedge clk);
        chk("fr_accepts", acc, 32);
        chk("fr_win", nwin, 12);
        chk("fr_sof", nsof, 1);
        chk("fr_eol", neol, 2);
        chk("fr_eof", neof, 1);
        chk("fr_done", ndone, 1);
        chk("fr_done_lat", done_c - last_acc_c, 1);
        chk("fr_fcnt", frame_cnt, exp_fc);
        chk("fr_idle", busy, 0);
    endtask

    initial begin
        pif.pix_valid = 1'b0;
        #2;
        chk("rst_state_busy", busy, 0);
        chk("rst_state_ready", pif.pix_ready, 0);
        chk("rst_state_win", pif.win_valid, 0);
        chk("rst_state_fcnt", frame_cnt, 0);
        chk("rst_state_err", err_timeout, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_no_en", busy, 0);

        run_frame(0, 0, 0, 0);  check_frame(1);
        run_frame(1, 0, 0, 0);  check_frame(2);

        run_frame(0, 20, 0, 0);
        chk("abort_ndone", ndone, 0);
        chk("abort_accepts", acc, 21);
        chk("abort_fcnt", frame_cnt, 2);
        run_frame(0, 0, 0, 0);  check_frame(3);

        run_frame(0, 0, 10, 0); check_frame(4);

        run_frame(0, 0, 0, 15);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pif.pix_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_shift", pif.shift_en, 0);
        pif.pix_valid = 1'b0;
        run_frame(0, 0, 0, 0);  check_frame(1);

`ifdef CTRL_TIMEOUT_EN
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pif.pix_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1 pif.pix_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("to_still_busy", busy, 1);
        chk("to_err_early", err_timeout, 0);
        @(posedge clk); #1;
        chk("to_idle", busy, 0);
        chk("to_err", err_timeout, 1);
        chk("to_done", done, 0);
        chk("to_fcnt", frame_cnt, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("to_err_clr", err_timeout, 0);
        chk("to_restart", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
`else
        chk("err_tied", err_timeout, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
